// File: rtl/ifu_pkg.sv
// rtl/ifu_pkg.sv - shared types and constants for the instruction fetch unit
package ifu_pkg;

    typedef enum logic {FETCH, HOLD} ifu_state_t;

    localparam int          BYTES_PER_WORD = 4;
    localparam logic [31:0] RESET_PC       = 32'h0;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } ifu_entry_t;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// rtl/instr_fetch_unit_if.sv - memory, redirect and instruction handshake bundle
interface instr_fetch_unit_if #(
    parameter int IMEM_AW = 7
);
    logic [IMEM_AW-1:0] imem_addr;
    logic [7:0]         imem_rdata;
    logic               redirect;
    logic [31:0]        redirect_pc;
    logic               instr_valid;
    logic               instr_ready;
    logic [31:0]        instr;
    logic [31:0]        instr_pc;
    logic [31:0]        instr_pc4;

    modport master (
        output imem_addr, instr_valid, instr, instr_pc, instr_pc4,
        input  imem_rdata, redirect, redirect_pc, instr_ready
    );

    modport slave (
        input  imem_addr, instr_valid, instr, instr_pc, instr_pc4,
        output imem_rdata, redirect, redirect_pc, instr_ready
    );
endinterface

// File: rtl/ifu_queue.sv
// rtl/ifu_queue.sv - prefetch FIFO of {instr, pc} with flush and push-on-full-with-pop
module ifu_queue
    import ifu_pkg::*;
#(
    parameter int QDEPTH = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       flush,
    input  logic       push,
    input  ifu_entry_t push_data,
    input  logic       pop,
    output logic       full,
    output logic       empty,
    output ifu_entry_t head
);
    localparam int PW = $clog2(QDEPTH);

    logic [PW:0] wr_ptr, rd_ptr;
    ifu_entry_t  mem [QDEPTH];
    logic        do_pop, do_push;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]) && (wr_ptr[PW] != rd_ptr[PW]);
    assign do_pop  = pop & ~empty;
    // A pop frees the slot in the same cycle, so a full queue can still accept
    assign do_push = push & (~full | do_pop);
    assign head    = empty ? '0 : mem[rd_ptr[PW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (PW+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (PW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr[PW-1:0]] <= push_data;
    end
endmodule

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - byte-serial big-endian instruction fetch with prefetch queue
module instr_fetch_unit
    import ifu_pkg::*;
#(
    parameter int IMEM_AW = 7,
    parameter int QDEPTH  = 2
) (
    input  logic                clk,
    input  logic                rst,
    instr_fetch_unit_if.master  bus
);
    localparam logic [1:0] LAST_BYTE = 2'(BYTES_PER_WORD - 1);

    ifu_state_t  state, state_nxt;
    logic [31:0] fetch_pc;
    logic [1:0]  byte_cnt;
    logic [31:0] asm_word;
    logic [4:0]  lane_lsb;
    logic        q_full, q_empty, pop, push, slot_free;
    ifu_entry_t  push_entry, head;

    assign bus.imem_addr   = fetch_pc[IMEM_AW-1:0] + IMEM_AW'(byte_cnt);
    assign bus.instr_valid = ~q_empty;
    assign bus.instr       = head.instr;
    assign bus.instr_pc    = head.pc;
    assign bus.instr_pc4   = q_empty ? '0 : head.pc + 32'(BYTES_PER_WORD);

    assign pop       = bus.instr_valid & bus.instr_ready;
    assign slot_free = ~q_full | pop;
    // Byte at PC lands in bits 31:24
    assign lane_lsb  = {LAST_BYTE - byte_cnt, 3'b000};

    always_comb begin
        state_nxt        = state;
        push             = 1'b0;
        push_entry       = '0;
        push_entry.instr = asm_word;
        push_entry.pc    = fetch_pc;
        case (state)
            FETCH: begin
                if (byte_cnt == LAST_BYTE) begin
                    push_entry.instr = {asm_word[31:8], bus.imem_rdata};
                    if (slot_free) push = 1'b1;
                    else           state_nxt = HOLD;
                end
            end
            HOLD: begin
                if (slot_free) begin
                    push      = 1'b1;
                    state_nxt = FETCH;
                end
            end
            default: state_nxt = FETCH;
        endcase
        if (bus.redirect) begin
            push      = 1'b0;
            state_nxt = FETCH;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= FETCH;
            fetch_pc <= RESET_PC;
            byte_cnt <= '0;
            asm_word <= '0;
        end else begin
            state <= state_nxt;
            if (bus.redirect) begin
                fetch_pc <= bus.redirect_pc & ~32'h3;
                byte_cnt <= '0;
                asm_word <= '0;
            end else begin
                // The last capture leaves the full word in asm_word for HOLD
                if (state == FETCH) asm_word[lane_lsb +: 8] <= bus.imem_rdata;
                if (push) begin
                    fetch_pc <= fetch_pc + 32'(BYTES_PER_WORD);
                    byte_cnt <= '0;
                end else if (state == FETCH && byte_cnt != LAST_BYTE) begin
                    byte_cnt <= byte_cnt + 2'd1;
                end
            end
        end
    end

    ifu_queue #(.QDEPTH(QDEPTH)) u_queue (
        .clk       (clk),
        .rst       (rst),
        .flush     (bus.redirect),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .full      (q_full),
        .empty     (q_empty),
        .head      (head)
    );
endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Byte-serial instruction fetch stage with a small prefetch queue, sitting directly upstream of the processor datapath. It walks the byte-wide instruction memory four locations at a time and assembles big-endian 32-bit instructions (byte at PC is bits 31:24). It delivers each instruction with its PC and PC+4 over a valid/ready handshake. The datapath steers it with a single-cycle redirect carrying the branch/jump target chosen by its next-PC muxes.

## Interface
- IMEM_AW, 7: instruction memory byte-address width (128 bytes).
- QDEPTH, 2: prefetch queue entries (power of two, ≥2).
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- imem_addr  out  IMEM_AW  byte address to instruction memory.
- imem_rdata  in  8  byte at imem_addr, combinational (same-cycle) read.
- redirect  in  1  one-cycle pulse: discard all prefetched state, refetch from redirect_pc.
- redirect_pc  in  32  new fetch PC; bits 1:0 ignored (forced to 0).
- instr_valid  out  1  queue head holds an instruction.
- instr_ready  in  1  datapath consumes the head this cycle.
- instr  out  32  head instruction; 0 when empty.
- instr_pc  out  32  PC of head; 0 when empty.
- instr_pc4  out  32  instr_pc + 4 (mod 2^32); 0 when empty.

## Operation
- Registers: fetch_pc (32), byte_cnt (2), asm_word (24 bits of captured bytes + held full word), queue of {instr, pc}.
- imem_addr = fetch_pc[IMEM_AW-1:0] + byte_cnt, modulo 2^IMEM_AW (wraps 0x7F→0x00); fetch_pc itself wraps mod 2^32.
- FSM states: FETCH, HOLD.
  - FETCH: each cycle capture imem_rdata into byte lane 3-byte_cnt, byte_cnt++. On byte_cnt==3: word complete; if queue has space (or a pop occurs this cycle) push {word, fetch_pc}, fetch_pc += 4, byte_cnt=0, stay FETCH; else latch word, go HOLD.
  - HOLD: imem_addr frozen, no capture. When a slot frees (pop this cycle or not full), push held word, fetch_pc += 4, byte_cnt=0, → FETCH.
- Pop: instr_valid & instr_ready at rising edge removes head. Push and pop in the same cycle on a full queue are both accepted.
- redirect (any state): at that edge queue cleared, partial/held word discarded, byte_cnt=0, fetch_pc={redirect_pc[31:2],2'b00}, state FETCH. A pop in the same cycle completes (datapath owns that instruction); no push occurs that cycle.
- rst overrides redirect and everything else.

## Timing
- Reset values: fetch_pc=0, byte_cnt=0, state FETCH, queue empty; instr_valid=0, instr=0, instr_pc=0, instr_pc4=0, imem_addr=0. Applied asynchronously on rst assertion.
- Latency: first instruction valid on the 4th rising edge after rst deasserts (cycles 0-3 read bytes, push at edge 4). Same 4-cycle latency after redirect, counted from the redirect edge +1.
- Steady throughput: one instruction per 4 cycles. After a stall, up to QDEPTH+1 instructions issue on consecutive cycles.
- Outputs are registered queue-head values; no combinational path from instr_ready or redirect to instr/instr_valid. imem_addr is combinational from registers only.

## Structure
- Package ifu_pkg: state enum {FETCH, HOLD}, BYTES_PER_WORD=4, RESET_PC=32'h0, queue entry typedef {instr[31:0], pc[31:0]}.
- Sub-module ifu_queue: QDEPTH-entry synchronous FIFO with async reset, flush input, simultaneous push/pop on full allowed; head exposed combinationally from its registers.
- Top: byte assembler, FSM, PC arithmetic, instr_pc4 adder.

## Test plan
- Reset, imem[0..7]=20 08 00 05 8C 09 00 04, ready=1 -> instr_valid rises at edge 4 with instr=32'h20080005, pc=0, pc4=4; next at edge 8 instr=32'h8C090004, pc=4.
- ready=0 for 20 cycles -> queue holds pc 0,4; state HOLD with pc 8 word; imem_addr stays 0x0B; raise ready -> pc 0,4,8 issued on 3 consecutive cycles, then 4-cycle spacing.
- Redirect redirect_pc=0x10 when byte_cnt=2 -> next imem_addr=0x10, instr_valid=0 next cycle, next issued instr_pc=0x10 four cycles later.
- redirect_pc=0x13 -> fetch from 0x10; instr_pc=0x10.
- Fetch through 0x7C -> bytes 0x7C-0x7F then imem_addr 0x00 with instr_pc=0x80, pc4=0x84.
- rst asserted between edges mid-word with queue non-empty -> instr_valid, instr, instr_pc, imem_addr go 0 immediately; fetch restarts at 0 after deassertion.
